// File: rtl/snake_pkg.sv
// Shared defaults and ring-index helper for the snake body buffer.
package snake_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned DEPTH_DEFAULT = 16;

    // depth must be a power of two, so mod-depth addition is a mask
    function automatic int unsigned ring_idx(input int unsigned ptr,
                                             input int unsigned offset,
                                             input int unsigned depth = DEPTH_DEFAULT);
        return (ptr + offset) & (depth - 1);
    endfunction

endpackage

// File: rtl/snake_body_match.sv
// Parallel comparison of a candidate head position against the occupied body segments.
module snake_body_match
    import snake_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic [WIDTH-1:0]       pos,
    input  logic [DEPTH*WIDTH-1:0] segs,
    input  logic [DEPTH-1:0]       mask,
    output logic                   hit
);

    logic [DEPTH-1:0] eq;

    always_comb begin
        eq = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eq[i] = (segs[WIDTH*i +: WIDTH] == pos);
        end
        hit = |(eq & mask);
    end

endmodule

// File: rtl/snake_body_buffer.sv
// Circular head-first buffer of snake segment positions with move/grow/init and collision detect.
module snake_body_buffer
    import snake_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEFAULT,
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   init_valid,
    input  logic [WIDTH-1:0]       init_pos,
    input  logic                   move_valid,
    input  logic [WIDTH-1:0]       move_pos,
    input  logic                   grow,
    output logic [LW-1:0]          length,
    output logic [WIDTH-1:0]       head_pos,
    output logic [WIDTH-1:0]       tail_pos,
    output logic [DEPTH*WIDTH-1:0] body_flat,
    output logic [DEPTH-1:0]       body_valid,
    output logic                   full,
    output logic                   collide
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PW-1:0]          head_ptr;
    logic [LW-1:0]          len_q;
    logic                   collide_q;

    logic [DEPTH*WIDTH-1:0] rot_flat;
    logic [DEPTH-1:0]       match_mask;
    logic [PW-1:0]          next_ptr;
    logic [LW-1:0]          match_limit;
    logic                   is_full;
    logic                   grow_eff;
    logic                   hit;

    assign is_full   = (len_q == LW'(DEPTH));
    assign grow_eff  = grow && !is_full;
    assign next_ptr  = head_ptr - PW'(1);
    // without growth the tail slot is vacated by this move, so it cannot be hit
    assign match_limit = grow_eff ? len_q : (len_q - LW'(1));

    always_comb begin
        rot_flat   = '0;
        body_flat  = '0;
        body_valid = '0;
        match_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rot_flat[WIDTH*i +: WIDTH] = mem[PW'(ring_idx(32'(head_ptr), i, DEPTH))];
            body_valid[i] = (LW'(i) < len_q);
            match_mask[i] = (LW'(i) < match_limit);
            if (body_valid[i]) begin
                body_flat[WIDTH*i +: WIDTH] = rot_flat[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        head_pos = '0;
        tail_pos = '0;
        if (len_q != '0) begin
            head_pos = mem[head_ptr];
            tail_pos = mem[head_ptr + PW'(len_q - LW'(1))];
        end
    end

    snake_body_match #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_match (
        .pos  (move_pos),
        .segs (rot_flat),
        .mask (match_mask),
        .hit  (hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head_ptr  <= '0;
            len_q     <= '0;
            collide_q <= 1'b0;
        end else if (init_valid) begin
            mem[0]    <= init_pos;
            head_ptr  <= '0;
            len_q     <= LW'(1);
            collide_q <= 1'b0;
        end else if (move_valid && (len_q != '0)) begin
            mem[next_ptr] <= move_pos;
            head_ptr      <= next_ptr;
            if (grow_eff) begin
                len_q <= len_q + LW'(1);
            end
            collide_q <= hit;
        end else begin
            collide_q <= 1'b0;
        end
    end

    assign length  = len_q;
    assign full    = is_full;
    assign collide = collide_q;

endmodule

// File: tb/tb_snake_body_buffer.sv
// Directed and randomized check of snake_body_buffer against a queue-based body model.
module tb_snake_body_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;
    localparam int unsigned FW    = DEPTH * WIDTH;

    logic             clock;
    logic             reset;
    logic             init_valid;
    logic [WIDTH-1:0] init_pos;
    logic             move_valid;
    logic [WIDTH-1:0] move_pos;
    logic             grow;
    logic [LW-1:0]    length;
    logic [WIDTH-1:0] head_pos;
    logic [WIDTH-1:0] tail_pos;
    logic [FW-1:0]    body_flat;
    logic [DEPTH-1:0] body_valid;
    logic             full;
    logic             collide;

    snake_body_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .init_valid (init_valid),
        .init_pos   (init_pos),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .grow       (grow),
        .length     (length),
        .head_pos   (head_pos),
        .tail_pos   (tail_pos),
        .body_flat  (body_flat),
        .body_valid (body_valid),
        .full       (full),
        .collide    (collide)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [WIDTH-1:0] body_q [$];
    logic             exp_collide = 1'b0;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Game-level meaning of one clock edge, applied to the head-first body list.
    task automatic model_edge();
        int unsigned n;
        int unsigned lim;
        bit          keep_tail;
        n = body_q.size();
        if (init_valid) begin
            body_q.delete();
            body_q.push_back(init_pos);
            exp_collide = 1'b0;
        end else if (move_valid && n > 0) begin
            keep_tail = grow && (n < DEPTH);
            lim = keep_tail ? n : n - 1;
            exp_collide = 1'b0;
            for (int unsigned i = 0; i < lim; i++) begin
                if (body_q[i] == move_pos) exp_collide = 1'b1;
            end
            body_q.push_front(move_pos);
            if (!keep_tail) void'(body_q.pop_back());
        end else begin
            exp_collide = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [FW-1:0]    ef;
        logic [DEPTH-1:0] ev;
        logic [WIDTH-1:0] eh;
        logic [WIDTH-1:0] et;
        int unsigned      n;
        n  = body_q.size();
        ef = '0;
        ev = '0;
        eh = '0;
        et = '0;
        for (int unsigned i = 0; i < n; i++) begin
            ef[WIDTH*i +: WIDTH] = body_q[i];
            ev[i] = 1'b1;
        end
        if (n > 0) begin
            eh = body_q[0];
            et = body_q[n-1];
        end
        check_eq("length",     FW'(length),     FW'(n));
        check_eq("head_pos",   FW'(head_pos),   FW'(eh));
        check_eq("tail_pos",   FW'(tail_pos),   FW'(et));
        check_eq("body_flat",  body_flat,       ef);
        check_eq("body_valid", FW'(body_valid), FW'(ev));
        check_eq("full",       FW'(full),       FW'(n == DEPTH));
        check_eq("collide",    FW'(collide),    FW'(exp_collide));
    endtask

    task automatic step(input logic iv, input logic [WIDTH-1:0] ip,
                        input logic mv, input logic [WIDTH-1:0] mp, input logic g);
        init_valid = iv;
        init_pos   = ip;
        move_valid = mv;
        move_pos   = mp;
        grow       = g;
        @(posedge clock);
        model_edge();
        #1;
        init_valid = 1'b0;
        move_valid = 1'b0;
        grow       = 1'b0;
        check_all();
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        #1;
        body_q.delete();
        exp_collide = 1'b0;
        check_all();
        check_eq("rst_flat_zero", body_flat, '0);
        #2;
        reset = 1'b0;
    endtask

    localparam logic [WIDTH-1:0] P_A = 32'h0005_0005;
    localparam logic [WIDTH-1:0] P_B = 32'h0006_0005;
    localparam logic [WIDTH-1:0] P_C = 32'h0007_0005;
    localparam logic [WIDTH-1:0] P_D = 32'h0008_0005;

    initial begin
        reset      = 1'b1;
        init_valid = 1'b0;
        init_pos   = '0;
        move_valid = 1'b0;
        move_pos   = '0;
        grow       = 1'b0;
        #12;
        check_all();
        reset = 1'b0;

        // basic init and growth
        step(1'b1, P_A, 1'b0, '0, 1'b0);
        check_eq("init_head_const", FW'(head_pos), FW'(P_A));
        step(1'b0, '0, 1'b1, P_B, 1'b1);
        step(1'b0, '0, 1'b1, P_C, 1'b1);
        step(1'b0, '0, 1'b1, P_D, 1'b1);
        check_eq("len4_tail_const", FW'(tail_pos), FW'(P_A));
        check_eq("len4_slot3_const", FW'(body_flat[WIDTH*3 +: WIDTH]), FW'(P_A));

        // fill to DEPTH, then grow while full so the ring wraps
        for (int unsigned k = 0; k < DEPTH - 4; k++) begin
            step(1'b0, '0, 1'b1, 32'h0100_0000 + k, 1'b1);
        end
        check_eq("full_const", FW'(full), FW'(1));
        step(1'b0, '0, 1'b1, 32'h0200_0000, 1'b1);
        step(1'b0, '0, 1'b1, 32'h0200_0001, 1'b1);

        // tail exclusion and body hit at length 4
        step(1'b1, P_A, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, P_B, 1'b1);
        step(1'b0, '0, 1'b1, P_C, 1'b1);
        step(1'b0, '0, 1'b1, P_D, 1'b1);
        step(1'b0, '0, 1'b1, P_A, 1'b0);
        check_eq("tail_move_no_collide", FW'(collide), FW'(0));
        step(1'b0, '0, 1'b1, P_D, 1'b0);
        check_eq("seg1_collide", FW'(collide), FW'(1));
        step(1'b0, '0, 1'b0, '0, 1'b0);

        // init wins over a simultaneous move
        step(1'b0, '0, 1'b1, 32'h0009_0005, 1'b1);
        step(1'b1, 32'h0010_0010, 1'b1, 32'h0011_0011, 1'b1);

        // asynchronous reset between edges, then a move at length 0
        step(1'b0, '0, 1'b1, 32'h0010_0011, 1'b1);
        async_reset_pulse();
        step(1'b0, '0, 1'b1, 32'h0003_0003, 1'b1);

        // randomized traffic over a small coordinate space to provoke collisions
        for (int unsigned t = 0; t < 400; t++) begin
            logic             r_iv;
            logic             r_mv;
            logic             r_g;
            logic [WIDTH-1:0] r_ip;
            logic [WIDTH-1:0] r_mp;
            r_iv = ($urandom_range(0, 24) == 0);
            r_mv = ($urandom_range(0, 3) != 0);
            r_g  = ($urandom_range(0, 2) == 0);
            r_ip = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
            r_mp = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
            if (t == 0) r_iv = 1'b1;
            step(r_iv, r_ip, r_mv, r_mp, r_g);
            if (t == 200) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule

// File: doc/snake_body_buffer.md
# snake_body_buffer

Parametrised circular buffer holding the snake's body segment positions, ordered head-first, with single-cycle move, grow and init operations. It replaces the fixed 10-entry indexed register bank and sits between the game-logic FSM and the VGA renderer. The buffer tracks length, head and tail positions, a full flag and a registered self-collision flag.

## Interface
- WIDTH, 32, bits per segment position (packed x/y coordinate; the buffer treats it as opaque).
- DEPTH, 16, maximum snake length in segments; must be ≥ 2 and a power of two.
- LW, $clog2(DEPTH+1), width of the length count (derived, not overridden).
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- init_valid  in  1  one-cycle pulse: restart the snake at init_pos with length 1.
- init_pos  in  WIDTH  start position.
- move_valid  in  1  one-cycle pulse: new head at move_pos.
- move_pos  in  WIDTH  new head position.
- grow  in  1  sampled with move_valid: 1 means keep the tail (length +1).
- length  out  LW  occupied segment count, 0..DEPTH.
- head_pos  out  WIDTH  segment 0; 0 when length==0.
- tail_pos  out  WIDTH  segment length-1; 0 when length==0.
- body_flat  out  DEPTH*WIDTH  segment i at bits [WIDTH*(i+1)-1 : WIDTH*i], head at i=0; unoccupied slots read 0.
- body_valid  out  DEPTH  bit i = 1 iff i < length.
- full  out  1  length==DEPTH.
- collide  out  1  registered one-cycle pulse: the last accepted move hit the body.

## Operation
- Storage: DEPTH×WIDTH register array mem plus head_ptr (log2 DEPTH bits). Segment i = mem[(head_ptr+i) mod DEPTH].
- Priority per cycle: reset > init_valid > move_valid.
- init: mem[0]←init_pos, head_ptr←0, length←1, collide←0. Other entries become don't-care and are masked on output.
- move, length==0: ignored; no state change and collide stays 0.
- move, length≥1: head_ptr←head_ptr−1 mod DEPTH; mem[new head_ptr]←move_pos.
  - grow=1 and length<DEPTH: length+1.
  - grow=0, or grow=1 with full: length unchanged. The old tail slot is overwritten or vacated by wrap-around.
- Collision: move_pos compared to segments 0..length−1. The tail segment is excluded when length is unchanged, because the tail vacates. A match sets collide=1 for the next cycle. The move is still applied; game logic decides the consequence.
- collide returns to 0 on every cycle without an accepted colliding move.
- Outputs are combinational from registers: no output logic depends on inputs in the same cycle.

## Timing
- Reset values: length=0, head_ptr=0, all mem=0, collide=0, full=0, body_flat=0, body_valid=0, head_pos=tail_pos=0.
- Reset asserted mid-operation clears all state asynchronously. Pulses in the release cycle are honoured only at the first rising edge with reset low.
- Latency 1: after a move or init accepted at edge N, all outputs reflect it from edge N onward. collide is high for exactly the cycle following edge N.
- Back-to-back moves on consecutive cycles are supported. Each move's collision check uses the body state before that move.
- init and move in the same cycle: init wins and the move is dropped.

## Structure
- Shared package snake_pkg: WIDTH default, DEPTH default, and function ring_idx(ptr, offset) for mod-DEPTH addition.
- One natural sub-module, snake_body_match. It is combinational: DEPTH parallel comparators of move_pos against the rotated segments, gated by an occupancy mask. It outputs a hit bit.
- Top level holds mem, head_ptr, length, the collide register, and the rotation mux producing body_flat.

## Test plan
- Reset, then init_pos=0x0005_0005 -> length=1, head_pos=tail_pos=0x0005_0005, body_valid=0x0001, collide=0.
- Three moves with grow=1 to 0x0006_0005, 0x0007_0005, 0x0008_0005 -> length=4, head_pos=0x0008_0005, tail_pos=0x0005_0005, body_flat slot 3=0x0005_0005.
- Grow to length 16 (DEPTH=16), then one more grow=1 move -> length stays 16, full=1, tail advances, head_ptr wraps cleanly.
- Length 4, grow=0 move onto current tail_pos -> collide=0. Same move onto segment 1 -> collide=1 for exactly one cycle, and the move is still applied.
- init_valid and move_valid together at length 5 -> length=1, head=init_pos, collide=0. move_valid at length 0 -> no change.
- Assert reset asynchronously between edges mid-sequence -> all outputs 0 immediately, before the next clock edge.
